regfile_param: RTL
==================

# regfile_param

Parametrised multi-read-port general register file for the CPU datapath. Its data width, depth and read-port count are parameters, and it has an asynchronous active-low reset. It keeps the zero-register, link-register write and same-cycle forwarding behaviour the core relies on. It adds a handshaked debug dump engine that streams every register out one per beat, and it sits between decode (read ports) and writeback/ALU (write and forward ports).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, index width; DEPTH = 2**ADDR_W registers
- NUM_READ, 2, number of combinational read ports
- ZERO_IDX, 0, hard-wired zero register index
- LINK_IDX, 13, link (return address) register index

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- wr_en  input  1  writeback write enable
- wr_addr  input  ADDR_W  writeback index
- wr_data  input  DATA_W  writeback value
- link_en  input  1  link-register write enable
- link_data  input  DATA_W  value for LINK_IDX
- fwd_en  input  1  ALU forward valid (never written to the array)
- fwd_addr  input  ADDR_W  forward index
- fwd_data  input  DATA_W  forward value
- rd_addr  input  NUM_READ*ADDR_W  packed read indices, port 0 in the LSBs
- rd_data  output  NUM_READ*DATA_W  packed read values, port 0 in the LSBs
- dump_start  input  1  single-cycle request to begin a dump
- dump_valid  output  1  dump beat valid
- dump_ready  input  1  consumer accepts the beat
- dump_idx  output  ADDR_W  index of the current beat
- dump_data  output  DATA_W  value of the current beat
- dump_last  output  1  high on the beat where dump_idx = DEPTH-1
- dump_busy  output  1  high from acceptance of dump_start until the last beat handshakes
- debug_out  output  DEPTH*DATA_W  flat image of the array; register 0 in the MSBs

## Operation
- Reset (rst low, asynchronous): all registers are cleared to 0. dump_valid, dump_last and dump_busy go to 0. dump_idx and dump_data go to 0.
- Writes at the rising edge:
  - wr_en writes wr_addr.
  - link_en writes LINK_IDX.
  - If both target LINK_IDX in the same cycle, the wr port wins.
  - Writes to ZERO_IDX are discarded.
- Reads are combinational per port. Priority order: ZERO_IDX always returns 0, then the forwarding path (see Configuration), then the array value.
- Dump FSM states:
  - IDLE: dump_start moves to SEND with the counter at 0. dump_start is ignored in every state other than IDLE.
  - SEND: dump_valid = 1, dump_data = live array value at dump_idx. On valid&&ready the counter increments. On valid&&ready&&last the FSM moves to IDLE.
- While dump_valid is high and dump_ready is low, dump_idx is held. dump_data tracks the array, so a write to that index during a stall is visible before the handshake.
- The counter stops at DEPTH-1; no wrap-around occurs within one dump.
- Reset mid-dump forces IDLE immediately. The next dump_start begins at index 0.

## Timing
- Read latency is 0 cycles (combinational from rd_addr and the array).
- Write to array is visible at rd_data from the cycle after the write edge.
- Dump: the first beat is valid in the cycle after dump_start is sampled. With dump_ready held high, a full dump takes DEPTH cycles, plus 1 cycle back to IDLE.
- dump_busy deasserts in the cycle after the last handshake. The same cycle can accept a new dump_start, since the FSM is back in IDLE.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Reads of a non-zero index use priority fwd (fwd_en && fwd_addr match) > wr (wr_en match) > link (link_en && index = LINK_IDX) > array.
  - Same-cycle writes are visible on rd_data.
- REGFILE_BYPASS_EN undefined:
  - rd_data is purely array (or 0 for ZERO_IDX).
  - fwd_* are ignored.
  - Writes become visible one cycle later.
- The dump path is unaffected by the macro; it always reads the array.

## Structure
- Shared package/header regfile_pkg holds:
  - default DATA_W, ADDR_W, ZERO_IDX and LINK_IDX constants
  - the dump FSM state encoding (IDLE = 0, SEND = 1)
- Sub-module regfile_dump contains the FSM, counter and handshake. Its interface: it receives the array read value for dump_idx and outputs the dump_* signals. The array and read muxes stay in the top module.

## Test plan
- Reset: pull rst low mid-cycle -> all rd_data = 0, debug_out = 0, dump_valid = 0 without waiting for a clock edge.
- Write r3 = 0x1234 with rd_addr port 0 = 3:
  - with bypass, rd_data port 0 = 0x1234 in the write cycle
  - without bypass, rd_data port 0 = 0x0000 in the write cycle and 0x1234 in the next cycle
- Write r0 = 0xFFFF with wr_en and fwd_en both targeting 0 -> r0 reads 0x0000 in the write cycle and afterwards.
- wr_en to 13 with 0xAAAA and link_en with 0x5555 in the same cycle -> r13 = 0xAAAA. With bypass, a same-cycle fwd_en to 13 with 0x0F0F reads 0x0F0F.
- Dump with preloaded rN = N*0x0101 and dump_ready toggled 1,0,1,… -> 16 beats with dump_idx 0..15 in order and data N*0x0101. Data is held during stalls. dump_last is high only at index 15. A dump_start pulsed mid-dump is ignored.
- Assert rst at dump_idx = 5 -> dump_valid = 0 and dump_busy = 0 immediately. After release, a new dump_start yields a first beat with dump_idx = 0 and dump_data = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and dump FSM encoding for the general register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Port summary: none (package). Imported by regfile_param and regfile_dump.
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_ZERO_IDX = 0;
    localparam int DEF_LINK_IDX = 13;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_SEND = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_dump.sv
// Debug dump engine: streams register indices 0..DEPTH-1 one beat per handshake.
// Latency: first beat valid the cycle after dump_start; one beat per accepted cycle.
// Backpressure: dump_ready low holds dump_idx; dump_data follows the live array value.
// Ports: dump_start (request, honoured only when idle), dump_ready (consumer accept),
//        rd_val (array value at dump_idx, supplied by the parent),
//        dump_valid/dump_idx/dump_data/dump_last/dump_busy (beat outputs).
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] rd_val,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              dump_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_SEND;
                    idx_d   = '0;
                end
            end
            DUMP_SEND: begin
                if (dump_ready) begin
                    // Counter saturates at the last index; the next dump restarts from 0.
                    if (idx_q == LAST_IDX) begin
                        state_d = DUMP_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = DUMP_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign dump_valid = (state_q == DUMP_SEND);
    assign dump_busy  = (state_q == DUMP_SEND);
    assign dump_idx   = idx_q;
    assign dump_last  = dump_valid && (idx_q == LAST_IDX);
    // Data is gated to zero outside a dump so the idle bus is quiet.
    assign dump_data  = dump_valid ? rd_val : '0;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with zero register, link write and dump port.
// Latency: reads combinational; writes land at the rising edge (same-cycle visible with bypass).
// Backpressure: only the dump stream is handshaked (dump_valid/dump_ready); other ports never stall.
// Ports: wr_* writeback, link_* link register write, fwd_* ALU forward (bypass builds only),
//        rd_addr/rd_data packed read ports (port 0 in LSBs), dump_* debug stream,
//        debug_out flat array image (register 0 in the MSBs).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle fwd/wr/link values onto rd_data.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = 2,
    parameter int ZERO_IDX = DEF_ZERO_IDX,
    parameter int LINK_IDX = DEF_LINK_IDX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         link_en,
    input  logic [DATA_W-1:0]            link_data,
    input  logic                         fwd_en,
    input  logic [ADDR_W-1:0]            fwd_addr,
    input  logic [DATA_W-1:0]            fwd_data,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    input  logic                         dump_start,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [ADDR_W-1:0]            dump_idx,
    output logic [DATA_W-1:0]            dump_data,
    output logic                         dump_last,
    output logic                         dump_busy,
    output logic [(2**ADDR_W)*DATA_W-1:0] debug_out
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Link write applied first so a writeback to the same index overrides it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (link_en && (LINK_A != ZERO_A)) begin
            regs_d[LINK_A] = link_data;
        end
        if (wr_en && (wr_addr != ZERO_A)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes: later assignments have higher priority; zero register last so it always wins.
    always_comb begin : rd_mux
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        rd_data = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            a = rd_addr[p*ADDR_W +: ADDR_W];
            v = regs_q[a];
`ifdef REGFILE_BYPASS_EN
            if (link_en && (a == LINK_A)) v = link_data;
            if (wr_en && (wr_addr == a))  v = wr_data;
            if (fwd_en && (fwd_addr == a)) v = fwd_data;
`endif
            if (a == ZERO_A) v = '0;
            rd_data[p*DATA_W +: DATA_W] = v;
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Forward inputs have no effect without bypass.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, fwd_addr, fwd_data};
`endif

    always_comb begin
        debug_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            debug_out[(DEPTH-1-i)*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    regfile_dump #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .rd_val     (regs_q[dump_idx]),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_busy  (dump_busy)
    );

endmodule
